// File: rtl/decodificador_gray_sinc.sv
// Gray-to-binary position decoder: synchronizes an asynchronous Gray code, qualifies
// stable codes, decodes them and hands each accepted position out via valid/ready.
module decodificador_gray_sinc #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir,
    output logic             jump,
    output logic             err_sticky,
    output logic             overrun
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_QUAL = 2'd2;

    logic [WIDTH-1:0] s1, g_sync, g_cand, g_stable;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;
    logic [1:0]       sync_fill;
    logic             first;

    logic             qual_en, same, accept, one_bit, step_up;
    logic [WIDTH-1:0] bin_new, bin_old, bin_inc;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Qualification only starts once g_sync holds a real sample, so the first code
    // after reset is counted from its own arrival rather than from the reset value.
    always_comb begin
        qual_en = sync_fill[1];
        same    = !first && (g_sync == g_cand);
        accept  = qual_en && same && (cnt == CNT_LAST) &&
                  ((state == ST_INIT) || (g_cand != g_stable));
        bin_new = gray2bin(g_cand);
        bin_old = gray2bin(g_stable);
        bin_inc = bin_old + WIDTH'(1);
        one_bit = ($countones(g_cand ^ g_stable) == 1);
        step_up = (bin_new == bin_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            g_sync    <= '0;
            sync_fill <= '0;
        end else begin
            s1        <= g_in;
            g_sync    <= s1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cand   <= '0;
            cnt      <= '0;
            first    <= 1'b1;
            g_stable <= '0;
            state    <= ST_INIT;
        end else begin
            if (qual_en) begin
                if (!same) begin
                    g_cand <= g_sync;
                    cnt    <= '0;
                    first  <= 1'b0;
                end else if (cnt < CNT_LAST) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (accept) begin
                g_stable <= g_cand;
                state    <= ST_IDLE;
            end else if (state != ST_INIT && qual_en) begin
                state <= (g_sync != g_stable) ? ST_QUAL : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            bin_out    <= '0;
            dir        <= 1'b0;
            jump       <= 1'b0;
            err_sticky <= 1'b0;
            overrun    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bin_out   <= bin_new;
            if (out_valid && !out_ready) overrun <= 1'b1;
            if (state == ST_INIT) begin
                jump <= 1'b0;
                dir  <= 1'b0;
            end else if (one_bit) begin
                jump <= 1'b0;
                dir  <= step_up;
            end else begin
                jump       <= 1'b1;
                dir        <= 1'b0;
                err_sticky <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decodificador_gray_sinc.sv
// Bench for decodificador_gray_sinc: directed scenarios against constants plus a
// randomized run checked cycle by cycle against a run-length reference model.
module tb_decodificador_gray_sinc;
    localparam int W  = 4;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] g_in;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] bin_out;
    logic         dir, jump, err_sticky, overrun;

    int tests = 0;
    int fails = 0;
    logic [W+1:0] words[$];

    decodificador_gray_sinc #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .g_in(g_in), .out_ready(out_ready),
        .out_valid(out_valid), .bin_out(bin_out), .dir(dir), .jump(jump),
        .err_sticky(err_sticky), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Binary bit i is the parity of Gray bits i..MSB.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference: g_sync is g_in delayed two edges; a code is accepted once it has been
    // seen in g_sync on more than SC consecutive qualifying edges and differs from the last one.
    int           m_edges, m_len;
    logic [W-1:0] m_d1, m_d2, m_run, m_stable, m_bin;
    bit           m_have, m_init, m_acc, m_valid, m_dir, m_jump, m_err, m_ovr;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_edges = 0; m_len = 0; m_d1 = 0; m_d2 = 0; m_run = 0; m_stable = 0;
            m_have = 0; m_init = 1; m_valid = 0; m_bin = 0; m_dir = 0; m_jump = 0;
            m_err = 0; m_ovr = 0;
        end else begin
            m_acc = 0;
            if (m_edges >= 2) begin
                if (!m_have || m_d2 != m_run) begin
                    m_run = m_d2; m_len = 1; m_have = 1;
                end else if (m_len < 1000) m_len++;
                m_acc = (m_len > SC) && (m_init || m_run != m_stable);
            end
            if (m_acc) begin
                if (m_valid && !out_ready) m_ovr = 1;
                m_valid = 1;
                m_bin = g2b(m_run);
                if (m_init) begin
                    m_jump = 0; m_dir = 0; m_init = 0;
                end else if ($countones(m_run ^ m_stable) == 1) begin
                    m_jump = 0;
                    m_dir = (g2b(m_run) == W'(g2b(m_stable) + 1));
                end else begin
                    m_jump = 1; m_dir = 0; m_err = 1;
                end
                m_stable = m_run;
            end else if (m_valid && out_ready) m_valid = 0;
            m_d2 = m_d1; m_d1 = g_in;
            if (m_edges < 1000) m_edges++;
        end
    end

    function automatic logic [W+4:0] dut_vec();
        return {out_valid, bin_out, dir, jump, err_sticky, overrun};
    endfunction

    function automatic logic [W+4:0] mdl_vec();
        return {m_valid, m_bin, m_dir, m_jump, m_err, m_ovr};
    endfunction

    task automatic do_reset(input logic [W-1:0] g, input logic r);
        @(negedge clk);
        rst = 1'b1; g_in = g; out_ready = r;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        words.delete();
    endtask

    task automatic drive(input logic [W-1:0] code, input int n);
        g_in = code;
        repeat (n) begin
            @(negedge clk);
            if (out_valid && out_ready) words.push_back({bin_out, dir, jump});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; g_in = '0; out_ready = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== '0) begin fails++; $display("FAIL reset_state got %h want 0", dut_vec()); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            tests++;
            if (e == 7) begin
                if ({out_valid, bin_out, dir, jump} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL latency_edge7 got %b want 1_0000_0_0", {out_valid, bin_out, dir, jump});
                end
            end else if (out_valid !== 1'b0) begin
                fails++; $display("FAIL latency_edge%0d out_valid got %b want 0", e, out_valid);
            end
        end
        out_ready = 1'b0;
        drive(4'b0001, 10);
        drive(4'b0110, 10);
        tests++;
        if ({out_valid, err_sticky, overrun} !== 3'b111) begin
            fails++; $display("FAIL pre_reset_state got %b want 111", {out_valid, err_sticky, overrun});
        end
        rst = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== '0) begin fails++; $display("FAIL reset_midrun got %h want 0", dut_vec()); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_up_sweep();
        do_reset(4'b0000, 1'b1);
        drive(4'b0000, 20);
        for (int k = 1; k < 16; k++) drive(b2g(W'(k)), 10);
        drive(4'b0000, 10);
        tests++;
        if (words.size() != 17) begin
            fails++; $display("FAIL up_sweep_count got %0d want 17", words.size());
        end else begin
            tests++;
            if (words[0] !== 6'b0000_00) begin fails++; $display("FAIL up_first got %b want 000000", words[0]); end
            for (int k = 1; k <= 16; k++) begin
                logic [W-1:0] eb;
                eb = W'(k % 16);
                tests++;
                if (words[k] !== {eb, 1'b1, 1'b0}) begin
                    fails++; $display("FAIL up_word%0d got %b want %b_1_0", k, words[k], eb);
                end
            end
        end
        tests++;
        if (err_sticky !== 1'b0) begin fails++; $display("FAIL up_err got %b want 0", err_sticky); end
    endtask

    task automatic test_down_sweep();
        do_reset(4'b0000, 1'b1);
        drive(4'b0000, 12);
        drive(4'b1000, 10);
        drive(4'b1001, 10);
        tests++;
        if (words.size() != 3) begin
            fails++; $display("FAIL down_count got %0d want 3", words.size());
        end else begin
            tests++;
            if (words[1] !== {4'd15, 1'b0, 1'b0}) begin fails++; $display("FAIL down_15 got %b want 1111_0_0", words[1]); end
            tests++;
            if (words[2] !== {4'd14, 1'b0, 1'b0}) begin fails++; $display("FAIL down_14 got %b want 1110_0_0", words[2]); end
        end
    endtask

    task automatic test_glitch_jump();
        do_reset(4'b0011, 1'b1);
        drive(4'b0011, 20);
        words.delete();
        drive(4'b0010, 2);
        drive(4'b0011, 15);
        tests++;
        if (words.size() != 0) begin fails++; $display("FAIL glitch_words got %0d want 0", words.size()); end
        out_ready = 1'b0;
        drive(4'b0110, 10);
        tests++;
        if ({out_valid, bin_out, dir, jump, err_sticky} !== {1'b1, 4'd4, 1'b0, 1'b1, 1'b1}) begin
            fails++; $display("FAIL jump_word got %b want 1_0100_0_1_1", {out_valid, bin_out, dir, jump, err_sticky});
        end
        drive(4'b0110, 5);
        tests++;
        if ({out_valid, bin_out, dir, jump} !== {1'b1, 4'd4, 1'b0, 1'b1}) begin
            fails++; $display("FAIL jump_hold got %b want 1_0100_0_1", {out_valid, bin_out, dir, jump});
        end
        out_ready = 1'b1;
        drive(4'b0110, 2);
        tests++;
        if ({out_valid, err_sticky} !== 2'b01) begin
            fails++; $display("FAIL err_sticky_kept got %b want 01", {out_valid, err_sticky});
        end
    endtask

    task automatic test_overrun();
        do_reset(4'b0000, 1'b0);
        drive(4'b0000, 12);
        drive(4'b0001, 10);
        drive(4'b0011, 10);
        tests++;
        if ({out_valid, bin_out, overrun} !== {1'b1, 4'd2, 1'b1}) begin
            fails++; $display("FAIL overrun got %b want 1_0010_1", {out_valid, bin_out, overrun});
        end
        do_reset(4'b0000, 1'b1);
        drive(4'b0000, 12);
        out_ready = 1'b0;
        drive(4'b0001, 10);
        g_in = 4'b0011;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, bin_out, dir, overrun} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
            fails++; $display("FAIL same_edge got %b want 1_0010_1_0", {out_valid, bin_out, dir, overrun});
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL same_edge_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_qualify();
        do_reset(4'b0000, 1'b1);
        drive(4'b0000, 12);
        g_in = 4'b0111;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== '0) begin fails++; $display("FAIL mid_qual_reset got %h want 0", dut_vec()); end
        @(negedge clk);
        rst = 1'b0;
        words.delete();
        drive(4'b0111, 12);
        tests++;
        if (words.size() != 1 || words[0] !== {4'd5, 1'b0, 1'b0} || err_sticky !== 1'b0) begin
            fails++; $display("FAIL mid_qual_first got n=%0d w=%b err=%b want n=1 w=0101_0_0 err=0",
                              words.size(), words.size() > 0 ? words[0] : 6'b0, err_sticky);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur;
        cur = W'($urandom);
        do_reset(cur, 1'b1);
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            if ($urandom_range(0, 9) < 7) cur = cur ^ W'(1 << $urandom_range(0, W - 1));
            else cur = W'($urandom);
            len = $urandom_range(1, 12);
            g_in = cur;
            if (seg == 30) begin
                rst = 1'b1;
                #1;
                tests++;
                if (dut_vec() !== mdl_vec()) begin
                    fails++; $display("FAIL random_reset got %h want %h", dut_vec(), mdl_vec());
                end
                @(negedge clk);
                rst = 1'b0;
            end
            repeat (len) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                tests++;
                if (dut_vec() !== mdl_vec()) begin
                    fails++; $display("FAIL random seg%0d got %h want %h", seg, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_glitch_jump();
        test_overrun();
        test_reset_mid_qualify();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
